// File: rtl/ram_arbiter.sv
// Round-robin arbiter/sequencer placing two valid/ready requesters onto a 16x8 single-port RAM.
// Define RAM_ARB_FIXED_PRIO_EN for fixed priority (A over B) instead of round-robin.
module ram_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req_valid,
  output logic              a_req_ready,
  input  logic              a_req_wr,
  input  logic [ADDR_W-1:0] a_req_addr,
  input  logic [DATA_W-1:0] a_req_wdata,
  output logic              a_rsp_valid,
  output logic [DATA_W-1:0] a_rsp_rdata,
  input  logic              b_req_valid,
  output logic              b_req_ready,
  input  logic              b_req_wr,
  input  logic [ADDR_W-1:0] b_req_addr,
  input  logic [DATA_W-1:0] b_req_wdata,
  output logic              b_rsp_valid,
  output logic [DATA_W-1:0] b_rsp_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE} state_t;

  state_t state, state_nxt;
  logic   grant_a, grant_b;
  logic   owner;          // 0 = A, 1 = B
`ifndef RAM_ARB_FIXED_PRIO_EN
  logic   last_grant;     // 0 = A, 1 = B
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    case (state)
      IDLE: begin
        if (!rst) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
          grant_a = a_req_valid;
`else
          grant_a = a_req_valid && (!b_req_valid || last_grant);
`endif
          grant_b = b_req_valid && !grant_a;
          if (grant_a || grant_b) state_nxt = ACCESS;
        end
      end
      // RAM samples the registered request at the closing edge of ACCESS
      ACCESS:  state_nxt = ram_wr ? IDLE : CAPTURE;
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign a_req_ready = grant_a;
  assign b_req_ready = grant_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_addr    <= '0;
      ram_wr      <= 1'b0;
      ram_din     <= '0;
      owner       <= 1'b0;
      a_rsp_valid <= 1'b0;
      b_rsp_valid <= 1'b0;
      a_rsp_rdata <= '0;
      b_rsp_rdata <= '0;
`ifndef RAM_ARB_FIXED_PRIO_EN
      last_grant  <= 1'b1;
`endif
    end else begin
      a_rsp_valid <= 1'b0;
      b_rsp_valid <= 1'b0;
      if (grant_a) begin
        ram_addr <= a_req_addr;
        ram_wr   <= a_req_wr;
        ram_din  <= a_req_wdata;
        owner    <= 1'b0;
`ifndef RAM_ARB_FIXED_PRIO_EN
        last_grant <= 1'b0;
`endif
      end else if (grant_b) begin
        ram_addr <= b_req_addr;
        ram_wr   <= b_req_wr;
        ram_din  <= b_req_wdata;
        owner    <= 1'b1;
`ifndef RAM_ARB_FIXED_PRIO_EN
        last_grant <= 1'b1;
`endif
      end
      if (state == ACCESS) ram_wr <= 1'b0;
      // ram_dout holds the registered read data only during CAPTURE
      if (state == CAPTURE) begin
        if (owner) begin
          b_rsp_valid <= 1'b1;
          b_rsp_rdata <= ram_dout;
        end else begin
          a_rsp_valid <= 1'b1;
          a_rsp_rdata <= ram_dout;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 16x8 registered-output RAM.
module tb_ram_arbiter;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              a_req_valid, a_req_ready, a_req_wr, a_rsp_valid;
  logic [ADDR_W-1:0] a_req_addr;
  logic [DATA_W-1:0] a_req_wdata, a_rsp_rdata;
  logic              b_req_valid, b_req_ready, b_req_wr, b_rsp_valid;
  logic [ADDR_W-1:0] b_req_addr;
  logic [DATA_W-1:0] b_req_wdata, b_rsp_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wr;
  logic [DATA_W-1:0] ram_din, ram_dout;
  logic [DATA_W-1:0] mem [16];

  int errors = 0;
  int checks = 0;
  int wr_cycles = 0;
  int a_rsp_cnt = 0;
  int b_rsp_cnt = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_wr(a_req_wr),
    .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
    .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_wr(b_req_wr),
    .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
    .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always @(posedge clk) begin
    if (ram_wr) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  always @(posedge clk) begin
    if (ram_wr)      wr_cycles++;
    if (a_rsp_valid) a_rsp_cnt++;
    if (b_rsp_valid) b_rsp_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic rv(input bit port);
    return port ? b_rsp_valid : a_rsp_valid;
  endfunction

  task automatic drive(input bit port, input bit wr, input logic [3:0] addr, input logic [7:0] d);
    if (port) begin
      b_req_valid = 1'b1; b_req_wr = wr; b_req_addr = addr; b_req_wdata = d;
    end else begin
      a_req_valid = 1'b1; a_req_wr = wr; a_req_addr = addr; a_req_wdata = d;
    end
  endtask

  task automatic drop(input bit port);
    if (port) b_req_valid = 1'b0;
    else      a_req_valid = 1'b0;
  endtask

  // Returns at the falling edge inside ACCESS of the accepted request.
  task automatic accept(input bit port, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (port ? b_req_ready : a_req_ready) ok = 1'b1;
      else @(negedge clk);
    end
    chk({tag, "_accept"}, ok, 1);
    if (ok) begin
      @(posedge clk);
      @(negedge clk);
    end
    drop(port);
  endtask

  task automatic wait_rsp(input bit port, input logic [7:0] exp, input string tag);
    chk({tag, "_lat0"}, rv(port), 0);
    @(negedge clk);
    chk({tag, "_lat1"}, rv(port), 0);
    @(negedge clk);
    chk({tag, "_valid"}, {rv(port), rv(!port)}, 2'b10);
    chk({tag, "_data"}, port ? b_rsp_rdata : a_rsp_rdata, exp);
    @(negedge clk);
    chk({tag, "_pulse"}, rv(port), 0);
  endtask

  task automatic rd(input bit port, input logic [3:0] addr, input logic [7:0] exp, input string tag);
    @(negedge clk);
    drive(port, 1'b0, addr, 8'h00);
    accept(port, tag);
    wait_rsp(port, exp, tag);
  endtask

  task automatic wr(input bit port, input logic [3:0] addr, input logic [7:0] d, input string tag);
    @(negedge clk);
    drive(port, 1'b1, addr, d);
    accept(port, tag);
    chk({tag, "_ram"}, {ram_wr, ram_addr, ram_din}, {1'b1, addr, d});
    @(negedge clk);
    chk({tag, "_wr_clr"}, ram_wr, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int wc0, ac, bc, g;
    rst = 1'b1;
    a_req_valid = 1'b1; a_req_wr = 1'b1; a_req_addr = 4'h0; a_req_wdata = 8'h00;
    b_req_valid = 1'b1; b_req_wr = 1'b0; b_req_addr = 4'h0; b_req_wdata = 8'h00;

    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", {a_req_ready, b_req_ready}, 0);
      chk("rst_ram", {ram_wr, ram_addr, ram_din}, 0);
      chk("rst_rsp", {a_rsp_valid, b_rsp_valid, a_rsp_rdata, b_rsp_rdata}, 0);
    end
    rst = 1'b0;
    #1;
    chk("first_grant", {a_req_ready, b_req_ready}, 2'b10);
    @(posedge clk);
    @(negedge clk);
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    @(negedge clk);

    wc0 = wr_cycles;
    wr(0, 4'h3, 8'h5A, "wr3");
    rd(0, 4'h3, 8'h5A, "rd3");
    chk("wr_pulse_cnt", wr_cycles - wc0, 1);
    chk("b_quiet", b_rsp_cnt, 0);

`ifdef RAM_ARB_FIXED_PRIO_EN
    @(negedge clk);
    drive(0, 1'b0, 4'h3, 8'h00);
    drive(1, 1'b0, 4'h3, 8'h00);
    g = 0;
    for (int c = 0; c < 60 && g < 6; c++) begin
      #1;
      chk("fp_b_ready", b_req_ready, 0);
      if (a_req_ready) g++;
      @(negedge clk);
    end
    chk("fp_grants", g, 6);
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    repeat (4) @(negedge clk);
`else
    wr(0, 4'h1, 8'h11, "pre1");
    wr(1, 4'h2, 8'h22, "pre2");
    ac = a_rsp_cnt;
    bc = b_rsp_cnt;
    @(negedge clk);
    drive(0, 1'b0, 4'h1, 8'h00);
    drive(1, 1'b0, 4'h2, 8'h00);
    g = 0;
    for (int c = 0; c < 40 && g < 4; c++) begin
      #1;
      chk("rr_excl", a_req_ready && b_req_ready, 0);
      if (a_req_ready || b_req_ready) begin
        chk("rr_order", b_req_ready, g % 2);
        g++;
      end
      if (a_rsp_valid) chk("rr_a_data", a_rsp_rdata, 8'h11);
      if (b_rsp_valid) chk("rr_b_data", b_rsp_rdata, 8'h22);
      @(negedge clk);
    end
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    repeat (4) begin
      #1;
      if (a_rsp_valid) chk("rr_a_data", a_rsp_rdata, 8'h11);
      if (b_rsp_valid) chk("rr_b_data", b_rsp_rdata, 8'h22);
      @(negedge clk);
    end
    chk("rr_grants", g, 4);
    chk("rr_a_cnt", a_rsp_cnt - ac, 2);
    chk("rr_b_cnt", b_rsp_cnt - bc, 2);

    // last grant was B: A's write to 0xF goes first, B reads the new value
    drive(0, 1'b1, 4'hF, 8'hFF);
    drive(1, 1'b0, 4'hF, 8'h00);
    #1;
    chk("ct1_grant", {a_req_ready, b_req_ready}, 2'b10);
    @(posedge clk);
    @(negedge clk);
    a_req_valid = 1'b0;
    chk("ct1_ram", {ram_wr, ram_addr, ram_din}, {1'b1, 4'hF, 8'hFF});
    accept(1, "ct1_b");
    wait_rsp(1, 8'hFF, "ct1_rd");
    rd(0, 4'h0, 8'h00, "no_alias");

    // last grant was A: B's read wins and sees the old 0xFF
    @(negedge clk);
    drive(0, 1'b1, 4'hF, 8'h3C);
    drive(1, 1'b0, 4'hF, 8'h00);
    #1;
    chk("ct2_grant", {a_req_ready, b_req_ready}, 2'b01);
    @(posedge clk);
    @(negedge clk);
    b_req_valid = 1'b0;
    wait_rsp(1, 8'hFF, "ct2_old");
    chk("ct2_wr", {ram_wr, ram_addr, ram_din}, {1'b1, 4'hF, 8'h3C});
    a_req_valid = 1'b0;
    rd(0, 4'hF, 8'h3C, "ct2_new");
`endif

    // reset during CAPTURE drops the response
    ac = a_rsp_cnt;
    @(negedge clk);
    drive(0, 1'b0, 4'h3, 8'h00);
    accept(0, "rstcap");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstcap_rsp", {a_rsp_valid, a_rsp_rdata}, 0);
    repeat (3) @(negedge clk);
    chk("rstcap_cnt", a_rsp_cnt - ac, 0);

    // reset during ACCESS of a write still commits it
    drive(0, 1'b1, 4'h5, 8'h77);
    accept(0, "rstacc");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstacc_wr", ram_wr, 0);
    rd(0, 4'h5, 8'h77, "rstacc_rd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
